// File: rtl/data_bus_pkg.sv
// Shared constants for the data-bus responder: MMIO register offsets and timer control bits.
package data_bus_pkg;

  localparam int unsigned MMIO_BASE_DEFAULT = 'hF0;

  localparam logic [3:0] OFF_GPIO_OUT  = 4'd0;
  localparam logic [3:0] OFF_GPIO_IN   = 4'd1;
  localparam logic [3:0] OFF_TMR_COUNT = 4'd2;
  localparam logic [3:0] OFF_TMR_CMP   = 4'd3;
  localparam logic [3:0] OFF_TMR_CTRL  = 4'd4;
  localparam logic [3:0] OFF_TMR_STAT  = 4'd5;
  localparam logic [3:0] OFF_ACC_CNT   = 4'd6;

  localparam int unsigned CTRL_EN         = 0;
  localparam int unsigned CTRL_AUTORELOAD = 1;
  localparam int unsigned CTRL_IRQ_EN     = 2;

endpackage

// File: rtl/mmio_timer.sv
// Compare timer: free-running COUNT with optional autoreload at CMP, sticky match flag
// and a registered interrupt level.
module mmio_timer
  import data_bus_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_count_i,
  input  logic              wr_cmp_i,
  input  logic              wr_ctrl_i,
  input  logic              wr_stat_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] count_o,
  output logic [DATA_W-1:0] cmp_o,
  output logic [DATA_W-1:0] ctrl_o,
  output logic [DATA_W-1:0] stat_o,
  output logic              timer_irq_o
);

  logic [DATA_W-1:0] count_q, count_d;
  logic [DATA_W-1:0] cmp_q, cmp_d;
  logic [2:0]        ctrl_q, ctrl_d;
  logic              flag_q, flag_d;
  logic              irq_q, irq_d;
  logic              match;

  always_comb begin
    // Compare uses the pre-update COUNT and the CMP value latched on an earlier edge.
    match   = ctrl_q[CTRL_EN] && (count_q == cmp_q);
    count_d = count_q;
    if (wr_count_i) begin
      count_d = wdata_i;
    end else if (ctrl_q[CTRL_EN]) begin
      if (match && ctrl_q[CTRL_AUTORELOAD]) begin
        count_d = '0;
      end else begin
        count_d = count_q + {{(DATA_W-1){1'b0}}, 1'b1};
      end
    end
    cmp_d  = wr_cmp_i ? wdata_i : cmp_q;
    ctrl_d = wr_ctrl_i ? wdata_i[2:0] : ctrl_q;
    flag_d = flag_q;
    if (match) begin
      flag_d = 1'b1;
    end else if (wr_stat_i && wdata_i[0]) begin
      flag_d = 1'b0;
    end
    irq_d = flag_q & ctrl_q[CTRL_IRQ_EN];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      cmp_q   <= '0;
      ctrl_q  <= '0;
      flag_q  <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      cmp_q   <= cmp_d;
      ctrl_q  <= ctrl_d;
      flag_q  <= flag_d;
      irq_q   <= irq_d;
    end
  end

  assign count_o     = count_q;
  assign cmp_o       = cmp_q;
  assign ctrl_o      = {{(DATA_W-3){1'b0}}, ctrl_q};
  assign stat_o      = {{(DATA_W-1){1'b0}}, flag_q};
  assign timer_irq_o = irq_q;

endmodule

// File: rtl/data_bus_responder.sv
// Data-memory responder: word RAM below MMIO_BASE, GPIO/timer/access-counter registers above.
// Reads are registered (1-cycle latency) and read-before-write on a same-edge write.
module data_bus_responder
  import data_bus_pkg::*;
#(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned MMIO_BASE = MMIO_BASE_DEFAULT,
  parameter int unsigned RAM_DEPTH = 240
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] data,
  input  logic              rden,
  input  logic              wren,
  output logic [DATA_W-1:0] q,
  input  logic [DATA_W-1:0] gpio_in,
  output logic [DATA_W-1:0] gpio_out,
  output logic              timer_irq
);

  localparam int unsigned       RamAw = $clog2(RAM_DEPTH);
  localparam logic [ADDR_W-1:0] Base  = ADDR_W'(MMIO_BASE);

  logic [DATA_W-1:0] ram [RAM_DEPTH];

  logic [DATA_W-1:0] q_q, gpio_out_q, gpio_s1_q, gpio_s2_q, acc_q;
  logic [DATA_W-1:0] rdata;
  logic [ADDR_W-1:0] offset_full;
  logic [3:0]        offset;
  logic              is_ram, mmio_hit, wr_mmio;
  logic              wr_gpio, wr_count, wr_cmp, wr_ctrl, wr_stat;
  logic [DATA_W-1:0] tmr_count, tmr_cmp, tmr_ctrl, tmr_stat;

  always_comb begin
    offset_full = address - Base;
    offset      = offset_full[3:0];
    is_ram      = address < Base;
    mmio_hit    = !is_ram && (offset_full < ADDR_W'(16));
    wr_mmio     = wren && mmio_hit;
    wr_gpio     = wr_mmio && (offset == OFF_GPIO_OUT);
    wr_count    = wr_mmio && (offset == OFF_TMR_COUNT);
    wr_cmp      = wr_mmio && (offset == OFF_TMR_CMP);
    wr_ctrl     = wr_mmio && (offset == OFF_TMR_CTRL);
    wr_stat     = wr_mmio && (offset == OFF_TMR_STAT);
  end

  // Read mux sees pre-edge state, which gives read-before-write for free.
  always_comb begin
    rdata = '0;
    if (is_ram) begin
      rdata = ram[address[RamAw-1:0]];
    end else if (mmio_hit) begin
      case (offset)
        OFF_GPIO_OUT:  rdata = gpio_out_q;
        OFF_GPIO_IN:   rdata = gpio_s2_q;
        OFF_TMR_COUNT: rdata = tmr_count;
        OFF_TMR_CMP:   rdata = tmr_cmp;
        OFF_TMR_CTRL:  rdata = tmr_ctrl;
        OFF_TMR_STAT:  rdata = tmr_stat;
        OFF_ACC_CNT:   rdata = acc_q;
        default:       rdata = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wren && is_ram) begin
      ram[address[RamAw-1:0]] <= data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q        <= '0;
      gpio_out_q <= '0;
      gpio_s1_q  <= '0;
      gpio_s2_q  <= '0;
      acc_q      <= '0;
    end else begin
      if (rden) begin
        q_q <= rdata;
      end
      if (wr_gpio) begin
        gpio_out_q <= data;
      end
      gpio_s1_q <= gpio_in;
      gpio_s2_q <= gpio_s1_q;
      if (wren) begin
        acc_q <= acc_q + {{(DATA_W-1){1'b0}}, 1'b1};
      end
    end
  end

  mmio_timer #(
    .DATA_W(DATA_W)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .wr_count_i (wr_count),
    .wr_cmp_i   (wr_cmp),
    .wr_ctrl_i  (wr_ctrl),
    .wr_stat_i  (wr_stat),
    .wdata_i    (data),
    .count_o    (tmr_count),
    .cmp_o      (tmr_cmp),
    .ctrl_o     (tmr_ctrl),
    .stat_o     (tmr_stat),
    .timer_irq_o(timer_irq)
  );

  assign q        = q_q;
  assign gpio_out = gpio_out_q;

endmodule
